// File: rtl/puf_challenge_sequencer_if.sv
// Bus bundle between the PUF challenge sequencer and its environment.
// slave: the sequencer side; master: the driving / observing side.
interface puf_challenge_sequencer_if;
  logic        start;
  logic [7:0]  base_challenge;
  logic [7:0]  count;
  logic [31:0] enable_mask;
  logic [31:0] puf_enable;
  logic [7:0]  puf_challenge;
  logic [7:0]  puf_out;
  logic        puf_all_done;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_data;
  logic [7:0]  resp_challenge;
  logic        busy;
  logic        done;
  logic        timeout_err;

  modport slave (
    input  start, base_challenge, count, enable_mask, puf_out, puf_all_done, resp_ready,
    output puf_enable, puf_challenge, resp_valid, resp_data, resp_challenge, busy, done,
           timeout_err
  );

  modport master (
    output start, base_challenge, count, enable_mask, puf_out, puf_all_done, resp_ready,
    input  puf_enable, puf_challenge, resp_valid, resp_data, resp_challenge, busy, done,
           timeout_err
  );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// Steps a PUF array through a batch of consecutive challenges and hands each response out.
// Optional EVAL watchdog enabled by defining PUF_SEQ_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start
// SETUP   | challenge applied, enable low, settling
// EVAL    | enable driven, waiting for puf_all_done
// PRESENT | response offered on resp_valid/resp_ready
// FINISH  | one-cycle done pulse
module puf_challenge_sequencer #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clock,
  input  logic                       computer_reset,
  puf_challenge_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EVAL, S_PRESENT, S_FINISH} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  chal_q, chal_d;
  logic [8:0]  rem_q, rem_d;
  logic [31:0] mask_q, mask_d;
  logic [7:0]  settle_q, settle_d;
  logic [31:0] puf_enable_q, puf_enable_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  resp_data_q, resp_data_d;
  logic [7:0]  resp_chal_q, resp_chal_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

`ifdef PUF_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;
  logic        terr_q, terr_d;
`else
  logic        unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d     = state_q;
    chal_d      = chal_q;
    rem_d       = rem_q;
    mask_d      = mask_q;
    settle_d    = settle_q;
    resp_data_d = resp_data_q;
    resp_chal_d = resp_chal_q;
`ifdef PUF_SEQ_TIMEOUT_EN
    tmo_d       = tmo_q;
    terr_d      = terr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          chal_d   = bus.base_challenge;
          rem_d    = (bus.count == 8'd0) ? 9'd256 : {1'b0, bus.count};
          mask_d   = bus.enable_mask;
          settle_d = SETTLE_LOAD;
          state_d  = S_SETUP;
`ifdef PUF_SEQ_TIMEOUT_EN
          terr_d   = 1'b0;
`endif
        end
      end
      S_SETUP: begin
        if (settle_q != 8'd0) begin
          settle_d = settle_q - 8'd1;
        end else if (!bus.puf_all_done) begin
          state_d = S_EVAL;
`ifdef PUF_SEQ_TIMEOUT_EN
          tmo_d   = TMO_LOAD;
`endif
        end
      end
      S_EVAL: begin
        if (bus.puf_all_done) begin
          resp_data_d = bus.puf_out;
          resp_chal_d = chal_q;
          state_d     = S_PRESENT;
        end
`ifdef PUF_SEQ_TIMEOUT_EN
        else if (tmo_q == 16'd0) begin
          terr_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
`endif
      end
      S_PRESENT: begin
        if (bus.resp_ready) begin
          rem_d  = rem_q - 9'd1;
          chal_d = chal_q + 8'd1;
          if (rem_q == 9'd1) begin
            state_d = S_FINISH;
          end else begin
            state_d  = S_SETUP;
            settle_d = SETTLE_LOAD;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    puf_enable_d = (state_d == S_EVAL) ? mask_d : 32'd0;
    resp_valid_d = (state_d == S_PRESENT);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FINISH);
  end

  always_ff @(posedge clock) begin
    if (computer_reset) begin
      state_q      <= S_IDLE;
      chal_q       <= 8'd0;
      rem_q        <= 9'd0;
      mask_q       <= 32'd0;
      settle_q     <= 8'd0;
      puf_enable_q <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'd0;
      resp_chal_q  <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      chal_q       <= chal_d;
      rem_q        <= rem_d;
      mask_q       <= mask_d;
      settle_q     <= settle_d;
      puf_enable_q <= puf_enable_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_chal_q  <= resp_chal_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef PUF_SEQ_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (computer_reset) begin
      tmo_q  <= 16'd0;
      terr_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      terr_q <= terr_d;
    end
  end
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.puf_enable     = puf_enable_q;
  assign bus.puf_challenge  = chal_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_challenge = resp_chal_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench for puf_challenge_sequencer: stimulus queues expected responses,
// a negedge monitor pops and compares them. Define PUF_SEQ_TIMEOUT_EN to cover the watchdog.
module tb_puf_challenge_sequencer;
  localparam int S = 4;
  localparam int T = 20;

  logic clock = 1'b0;
  logic computer_reset = 1'b1;
  always #5 clock = ~clock;

  puf_challenge_sequencer_if bus();

  puf_challenge_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clock          (clock),
    .computer_reset (computer_reset),
    .bus            (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_seen = 0;
  int en_cycles = 0;
  int en_cnt = 0;
  int puf_delay = 0;
  bit never_done = 1'b0;
  int ready_mode = 0;
  int stall_ctr = 0;
  logic [31:0] cur_mask = '0;
  logic [7:0] exp_chal[$];
  int lat_q[$];

  logic prev_valid, prev_ready, prev_done;
  logic [7:0] prev_data, prev_chal;

  function automatic logic [7:0] puf_f(input logic [7:0] c);
    return {c[3:0], c[7:4]} ^ 8'h5A;
  endfunction

  // PUF array model: completes puf_delay cycles after enable rises (0 = same cycle).
  always @(posedge clock) begin
    if (bus.puf_enable != '0) en_cnt <= en_cnt + 1;
    else en_cnt <= 0;
    cyc <= cyc + 1;
  end
  assign bus.puf_all_done = (bus.puf_enable != '0) && !never_done && (en_cnt >= puf_delay);
  assign bus.puf_out      = puf_f(bus.puf_challenge);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: bus.resp_ready = 1'b1;
        1: bus.resp_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.resp_valid && stall_ctr < 10) begin
            bus.resp_ready = 1'b0;
            stall_ctr++;
          end else begin
            bus.resp_ready = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin : monitor
    logic [7:0] ch;
    int l;
    forever begin
      @(negedge clock);
      if (computer_reset) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (bus.puf_enable != '0) begin
          en_cycles++;
          check("enable_word", {31'd0, bus.resp_valid, bus.puf_enable}, {32'd0, cur_mask});
          if (exp_chal.size() > 0) check("eval_challenge", 64'(bus.puf_challenge), 64'(exp_chal[0]));
        end
        if (bus.resp_valid && prev_valid && !prev_ready)
          check("stall_hold", {48'd0, bus.resp_data, bus.resp_challenge}, {48'd0, prev_data, prev_chal});
        if (bus.resp_valid && bus.resp_ready) begin
          check("resp_expected", 64'(exp_chal.size() > 0), 64'd1);
          if (exp_chal.size() > 0) begin
            ch = exp_chal.pop_front();
            check("resp_challenge", 64'(bus.resp_challenge), 64'(ch));
            check("resp_data", 64'(bus.resp_data), 64'(puf_f(ch)));
          end
        end
        if (bus.done) begin
          done_seen++;
          check("done_width", 64'(prev_done), 64'd0);
          check("done_expected", 64'(lat_q.size() > 0), 64'd1);
          if (lat_q.size() > 0) begin
            l = lat_q.pop_front();
            if (l >= 0) check("latency", 64'(cyc - start_cyc + 1), 64'(l));
          end
          check("done_resp_left", 64'(exp_chal.size()), 64'd0);
        end
        prev_valid = bus.resp_valid;
        prev_ready = bus.resp_ready;
        prev_done  = bus.done;
        prev_data  = bus.resp_data;
        prev_chal  = bus.resp_challenge;
      end
    end
  end

  task automatic start_batch(input logic [7:0] b, input logic [7:0] c, input logic [31:0] m,
                             input int dly, input int mode, input bit nd);
    int n;
    logic [7:0] ch;
    n = (c == 8'd0) ? 256 : int'(c);
    @(posedge clock);
    #1;
    puf_delay  = dly;
    never_done = nd;
    ready_mode = mode;
    stall_ctr  = 0;
    cur_mask   = m;
    en_cycles  = 0;
    bus.start  = 1'b1;
    bus.base_challenge = b;
    bus.count = c;
    bus.enable_mask = m;
    start_cyc = cyc;
    if (!nd) begin
      for (int i = 0; i < n; i++) begin
        ch = b + 8'(i);
        exp_chal.push_back(ch);
      end
      lat_q.push_back((dly == 0 && mode == 0) ? n * (S + 2) + 2 : -1);
    end
`ifdef PUF_SEQ_TIMEOUT_EN
    else lat_q.push_back(S + T + 2);
`endif
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.base_challenge = 8'($urandom);
    bus.count = 8'($urandom);
    bus.enable_mask = $urandom;
    @(negedge clock);
    check("busy_after_start", 64'(bus.busy), 64'd1);
    check("terr_after_start", 64'(bus.timeout_err), 64'd0);
  endtask

  task automatic wait_done(input int bound);
    int tgt;
    int k;
    tgt = done_seen + 1;
    k = 0;
    while (done_seen < tgt && k < bound) begin
      @(negedge clock);
      k++;
    end
    check("done_reached", 64'(done_seen >= tgt), 64'd1);
    @(negedge clock);
    check("idle_after_done", 64'(bus.busy), 64'd0);
  endtask

  task automatic reset_and_check();
    @(posedge clock);
    #1;
    computer_reset = 1'b1;
    exp_chal.delete();
    lat_q.delete();
    @(posedge clock);
    #1;
    check("reset_outputs",
          {4'd0, bus.puf_enable, bus.puf_challenge, bus.resp_valid, bus.resp_data,
           bus.resp_challenge, bus.busy, bus.done, bus.timeout_err}, 64'd0);
    computer_reset = 1'b0;
    repeat (5) @(negedge clock);
    check("idle_after_reset", 64'(bus.busy), 64'd0);
  endtask

  initial begin : stimulus
    int wait_k;
    logic [7:0] rb;
    logic [7:0] rc;
    int rd;
    int rm;
    bus.start = 1'b0;
    bus.base_challenge = 8'h00;
    bus.count = 8'h00;
    bus.enable_mask = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs_init",
          {4'd0, bus.puf_enable, bus.puf_challenge, bus.resp_valid, bus.resp_data,
           bus.resp_challenge, bus.busy, bus.done, bus.timeout_err}, 64'd0);
    computer_reset = 1'b0;

    start_batch(8'h10, 8'd3, 32'hA5A5_0F0F, 5, 0, 1'b0);
    wait_done(200);

    start_batch(8'hFE, 8'd3, 32'h0000_0001, 0, 0, 1'b0);
    wait_done(200);

    start_batch(8'h33, 8'd2, 32'hFFFF_FFFF, 2, 2, 1'b0);
    wait_done(200);
    check("stall_cycles", 64'(stall_ctr), 64'd10);

    start_batch(8'h80, 8'd0, 32'h1234_5678, 0, 0, 1'b0);
    wait_done(256 * (S + 2) + 50);

`ifdef PUF_SEQ_TIMEOUT_EN
    start_batch(8'h40, 8'd2, 32'hDEAD_BEEF, 0, 0, 1'b1);
    wait_done(200);
    check("timeout_err_set", 64'(bus.timeout_err), 64'd1);
    check("timeout_eval_cycles", 64'(en_cycles), 64'(T));
    repeat (5) @(negedge clock);
    check("timeout_err_sticky", 64'(bus.timeout_err), 64'd1);
    never_done = 1'b0;
`else
    start_batch(8'h40, 8'd2, 32'hDEAD_BEEF, 0, 0, 1'b1);
    repeat (300) @(negedge clock);
    check("eval_waits_busy", 64'(bus.busy), 64'd1);
    check("eval_waits_enable", 64'(bus.puf_enable), 64'(32'hDEAD_BEEF));
    check("no_timeout_err", 64'(bus.timeout_err), 64'd0);
    reset_and_check();
    never_done = 1'b0;
`endif

    start_batch(8'h20, 8'd4, 32'h0F0F_F0F0, 3, 0, 1'b0);
    wait_k = 0;
    while (bus.puf_enable == '0 && wait_k < 100) begin
      @(negedge clock);
      wait_k++;
    end
    check("reached_eval", 64'(bus.puf_enable != '0), 64'd1);
    reset_and_check();

    @(posedge clock);
    #1;
    computer_reset = 1'b1;
    bus.start = 1'b1;
    bus.base_challenge = 8'h77;
    bus.count = 8'd1;
    @(posedge clock);
    #1;
    computer_reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clock);
    check("reset_beats_start", {55'd0, bus.busy, bus.puf_challenge}, 64'd0);

    for (int r = 0; r < 6; r++) begin
      rb = 8'($urandom);
      rc = 8'($urandom_range(1, 6));
      rd = int'($urandom_range(0, 3));
      rm = int'($urandom_range(0, 1));
      start_batch(rb, rc, $urandom | 32'd1, rd, rm, 1'b0);
      wait_done(2000);
    end

    check("final_lat_queue", 64'(lat_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/puf_challenge_sequencer.md
PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles spent in SETUP with puf_enable low before evaluation (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum EVAL cycles while waiting for puf_all_done (range 1..65535).
REQ-003 SHALL use one clock and a synchronous, active-high reset:
- clock  in  1  sole clock, rising edge.
- computer_reset  in  1  synchronous active-high reset.
REQ-004 SHALL have the remaining ports:
- start  in  1  start-of-batch request, sampled in IDLE only.
- base_challenge  in  8  first challenge of the batch.
- count  in  8  number of challenges in the batch; 0 means 256.
- enable_mask  in  32  word driven onto puf_enable during EVAL.
- puf_enable  out  32  enable to the PUF array.
- puf_challenge  out  8  challenge to the PUF array.
- puf_out  in  8  response from the PUF array.
- puf_all_done  in  1  PUF array completion flag.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  8  captured response.
- resp_challenge  out  8  challenge that produced resp_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at batch end.
- timeout_err  out  1  sticky error flag.

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, EVAL, PRESENT and FINISH.
REQ-006 IDLE: when start=1, SHALL latch base_challenge into the challenge register, latch count (0 loaded as 256) into a 9-bit remaining counter, latch enable_mask, and go to SETUP on the next edge.
REQ-007 SETUP: SHALL drive puf_enable=0 and puf_challenge=current challenge.
REQ-008 SETUP SHALL go to EVAL only once SETTLE_CYCLES cycles have elapsed in SETUP and puf_all_done=0.
REQ-009 EVAL: SHALL drive puf_enable=latched mask and hold puf_challenge stable.
REQ-010 EVAL: on the first cycle with puf_all_done=1, SHALL capture resp_data=puf_out and resp_challenge=current challenge, then go to PRESENT.
REQ-011 PRESENT: SHALL drive resp_valid=1 and puf_enable=0.
REQ-012 PRESENT: resp_data and resp_challenge SHALL stay stable while resp_valid=1 and resp_ready=0.
REQ-013 PRESENT: on a cycle with resp_valid=1 and resp_ready=1, SHALL decrement remaining and increment the challenge modulo 256 (8'hFF wraps to 8'h00).
REQ-014 After that handshake, SHALL go to SETUP if remaining after decrement is non-zero, otherwise to FINISH.
REQ-015 FINISH: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-016 start SHALL be ignored in every state except IDLE.
REQ-017 Latency: a batch of N challenges with zero PUF delay and resp_ready tied high SHALL take N*(SETTLE_CYCLES+2)+2 cycles from the start edge to the done pulse.
REQ-018 puf_enable SHALL be 0 in IDLE, SETUP, PRESENT and FINISH.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 computer_reset=1 SHALL force IDLE from any state, including mid-batch, with no done pulse.
REQ-021 On reset, all outputs SHALL be 0, including timeout_err; all counters SHALL be cleared.
REQ-022 If reset coincides with start, reset SHALL win.

Configuration
REQ-023 Macro PUF_SEQ_TIMEOUT_EN defined: an EVAL cycle counter SHALL run.
REQ-024 With PUF_SEQ_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without puf_all_done SHALL set timeout_err, skip PRESENT, and go to FINISH (done pulses).
REQ-025 With PUF_SEQ_TIMEOUT_EN defined, timeout_err SHALL stay set until reset or the next accepted start.
REQ-026 PUF_SEQ_TIMEOUT_EN undefined: EVAL SHALL wait indefinitely, timeout_err SHALL be constant 0, and no timeout counter SHALL be synthesized.

Verification
REQ-027 start, base_challenge=8'h10, count=3, model all_done 5 cycles after enable, resp_ready=1 -> three responses with resp_challenge 10,11,12, then one done pulse.
REQ-028 base_challenge=8'hFE, count=3 -> resp_challenge FE, FF, 00.
REQ-029 resp_ready low 10 cycles in PRESENT -> resp_data and resp_challenge stable; no further puf_enable until accept.
REQ-030 count=0 -> exactly 256 responses, then done.
REQ-031 PUF_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=20, all_done never asserted -> timeout_err=1 and done pulse after 20 EVAL cycles; resp_valid never asserted.
REQ-032 computer_reset asserted in EVAL mid-batch -> next cycle all outputs 0, IDLE, no done; a new start then runs normally.
